// File: rtl/alu_seq_exec.sv
// Sequential ALU execute stage: one op per valid/ready handshake, result held until accepted.
// Define FAST_SHIFT_EN for a single-cycle barrel shifter; default build shifts one bit per cycle.
module alu_seq_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

`ifdef FAST_SHIFT_EN
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t            r_state;
  logic [XLEN-1:0]   r_result;
  logic              r_valid;
  logic              r_zero;
  logic              r_illegal;

  logic              w_accept;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]   w_result;
  logic              w_illegal;

  assign ready_o   = (r_state == S_IDLE);
  assign w_accept  = valid_i & ready_o;
  assign w_shamt   = op_b_i[SHAMT_W-1:0];
  assign valid_o   = r_valid;
  assign result_o  = r_result;
  assign zero_o    = r_zero;
  assign illegal_o = r_illegal;

  // Single-cycle result; in the serial build a shift lands here only when shamt is 0.
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (alu_ctrl_i)
      OP_ADD:  w_result = op_a_i + op_b_i;
      OP_SUB:  w_result = op_a_i - op_b_i;
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
      OP_XOR:  w_result = op_a_i ^ op_b_i;
      OP_OR:   w_result = op_a_i | op_b_i;
      OP_AND:  w_result = op_a_i & op_b_i;
`ifdef FAST_SHIFT_EN
      OP_SLL:  w_result = op_a_i << w_shamt;
      OP_SRL:  w_result = op_a_i >> w_shamt;
      OP_SRA:  w_result = XLEN'($signed(op_a_i) >>> w_shamt);
`else
      OP_SLL, OP_SRL, OP_SRA: w_result = op_a_i;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

`ifndef FAST_SHIFT_EN
  logic [3:0]         r_ctrl;
  logic [SHAMT_W-1:0] r_cnt;
  logic               w_is_shift;
  logic [XLEN-1:0]    w_shift_next;

  assign w_is_shift = (alu_ctrl_i == OP_SLL) || (alu_ctrl_i == OP_SRL) ||
                      (alu_ctrl_i == OP_SRA);

  always_comb begin
    case (r_ctrl)
      OP_SLL:  w_shift_next = {r_result[XLEN-2:0], 1'b0};
      OP_SRL:  w_shift_next = {1'b0, r_result[XLEN-1:1]};
      default: w_shift_next = {r_result[XLEN-1], r_result[XLEN-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifndef FAST_SHIFT_EN
      r_ctrl    <= '0;
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifndef FAST_SHIFT_EN
            if (w_is_shift && (w_shamt != '0)) begin
              r_result <= op_a_i;
              r_ctrl   <= alu_ctrl_i;
              r_cnt    <= w_shamt;
              r_state  <= S_SHIFT;
            end else
`endif
            begin
              r_result  <= w_result;
              r_zero    <= (w_result == '0);
              r_illegal <= w_illegal;
              r_valid   <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
`ifndef FAST_SHIFT_EN
        S_SHIFT: begin
          r_result <= w_shift_next;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_zero  <= (w_shift_next == '0);
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (ready_i) begin
            r_valid   <= 1'b0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: driver pushes expectations, monitor pops on valid_o.
module tb_alu_seq_exec;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  alu_ctrl_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;

  alu_seq_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .alu_ctrl_i(alu_ctrl_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          hold;   // -1: random backpressure
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   mon_busy = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model straight from the op table.
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, output logic ill);
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return a | b;
      4'd9: return a & b;
      default: begin ill = 1'b1; return 32'd0; end
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] c, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    if (c == 4'd2 || c == 4'd6 || c == 4'd7) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  // Called at a negedge; returns at a negedge after the request was taken.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    int n;
    alu_ctrl_i = c; op_a_i = a; op_b_i = b; valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      errors++; checks++;
      $display("FAIL accept_timeout: ready_o=%0b required=1", ready_o);
      valid_i = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    q.push_back(e);
    $display("issue ctrl=%0d a=0x%08h b=0x%08h exp=0x%08h lat=%0d", c, a, b, e.res, e.lat);
    // Scramble inputs with valid_i high while busy; must be ignored.
    @(negedge clk_i);
    alu_ctrl_i = 4'($urandom); op_a_i = $urandom; op_b_i = $urandom; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic issue_dir(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic ill, input int lat, input int hold);
    exp_t e;
    e.res = res; e.zero = (res == 32'd0); e.ill = ill; e.lat = lat; e.hold = hold; e.acc = 0;
    issue(c, a, b, e);
  endtask

  task automatic issue_rand(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic il;
    e.res = model(c, a, b, il); e.zero = (e.res == 32'd0); e.ill = il;
    e.lat = lat_of(c, b); e.hold = -1; e.acc = 0;
    issue(c, a, b, e);
  endtask

  // Monitor / scoreboard checker
  initial begin
    exp_t e;
    int hold;
    logic [31:0] snap;
    ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (valid_o) begin
          mon_busy = 1'b1;
          if (q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_valid: result=0x%08h with empty scoreboard", result_o);
            ready_i = 1'b1;
            @(negedge clk_i);
            ready_i = 1'b0;
          end else begin
            e = q.pop_front();
            $display("result 0x%08h zero=%0b ill=%0b lat=%0d (exp 0x%08h lat %0d)",
                     result_o, zero_o, illegal_o, cyc - e.acc + 1, e.res, e.lat);
            chk("result", result_o, e.res);
            chk("zero", 32'(zero_o), 32'(e.zero));
            chk("illegal", 32'(illegal_o), 32'(e.ill));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            snap = result_o;
            hold = (e.hold < 0) ? int'($urandom_range(0, 3)) : e.hold;
            for (int i = 0; i < hold; i++) begin
              @(negedge clk_i);
              chk("hold_valid", 32'(valid_o), 32'd1);
              chk("hold_result", result_o, snap);
              chk("hold_zero", 32'(zero_o), 32'(e.zero));
              chk("hold_illegal", 32'(illegal_o), 32'(e.ill));
              chk("hold_ready_o", 32'(ready_o), 32'd0);
            end
            ready_i = 1'b1;
            @(negedge clk_i);
            ready_i = 1'b0;
            chk("post_hs_valid", 32'(valid_o), 32'd0);
            chk("post_hs_ready_o", 32'(ready_o), 32'd1);
            chk("post_hs_flags", {30'd0, zero_o, illegal_o}, 32'd0);
          end
          mon_busy = 1'b0;
        end else if (zero_o || illegal_o) begin
          chk("flags_idle", {30'd0, zero_o, illegal_o}, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    int          n;
    rst_ni = 1'b0; valid_i = 1'b0; alu_ctrl_i = '0; op_a_i = '0; op_b_i = '0;
    #3;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_flags", {30'd0, zero_o, illegal_o}, 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i); rst_ni = 1'b1;

    // Reset mid-shift: SLL shamt 20, reset on the fifth cycle.
    @(negedge clk_i);
    alu_ctrl_i = 4'd2; op_a_i = 32'h0000_0001; op_b_i = 32'd20; valid_i = 1'b1;
    @(negedge clk_i); valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("shift_busy_ready", 32'(ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("midshift_rst_valid", 32'(valid_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    chk("after_rst_ready", 32'(ready_o), 32'd1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (valid_o) n++;
    end
    chk("no_stale_result", 32'(n), 32'd0);
    $display("reset-abort sequence done");

    mon_en = 1'b1;
    issue_dir(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0, 1, -1);
    issue_dir(4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, -1);
    issue_dir(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, -1);
    issue_dir(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, -1);
`ifdef FAST_SHIFT_EN
    issue_dir(4'd7, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 1, -1);
    issue_dir(4'd6, 32'h8000_0000, 32'h1F, 32'h0000_0001, 1'b0, 1, -1);
`else
    issue_dir(4'd7, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 32, -1);
    issue_dir(4'd6, 32'h8000_0000, 32'h1F, 32'h0000_0001, 1'b0, 32, -1);
`endif
    issue_dir(4'd2, 32'h8000_0000, 32'h20, 32'h8000_0000, 1'b0, 1, -1);
    issue_dir(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 4);
    issue_dir(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1, -1);
    issue_dir(4'd2, 32'h0000_0001, 32'd1, 32'h0000_0002, 1'b0, lat_of(4'd2, 32'd1), 0);

    for (int i = 0; i < 150; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h8000_0000;
        2: a = 32'd0;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue_rand(c, a, b);
    end

    n = 0;
    while ((q.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (q.size() != 0 || mon_busy) begin
      errors++; checks++;
      $display("FAIL drain_timeout: pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
